echo_canceller_lms: RTL

Parametrised adaptive echo canceller. It is the next generation of the fixed four-tap, fixed-lag `echo_cancelation_full` stage.

- Removes the far-end echo from the near-end 16-bit sample stream.
- Uses a TAPS-long FIR whose coefficients adapt by LMS on every sample.
- Sits after the sig16b conversion stage and is strobed once per sampling period by the sampling controller.
- Is fully fixed-point and sequential: one shared multiplier, one tap per clock.

---
 rtl/echo_pkg.sv | 47 ++++
 rtl/echo_sat_round.sv | 19 +
 rtl/echo_canceller_lms.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/echo_pkg.sv
// echo_pkg: shared types and fixed-point helpers for the LMS echo canceller.
//   state_t       - controller state encoding (IDLE/FILTER/ERROR/UPDATE)
//   acc_width()   - MAC accumulator width: COEF_W + DATA_W + clog2(TAPS)
//   upd_shift()   - coefficient-update shift S = 2*DATA_W-2-FRAC_W+MU_SHIFT
//   sat_to_width()- clamp a signed value to the range of a w-bit signed word
//   round_shift() - arithmetic right shift with round-half-up
// The helpers work on 64-bit signed values, so every operand width fed
// through them must stay below 63 bits.
package echo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILTER = 2'd1,
        ST_ERROR  = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    function automatic int unsigned acc_width(input int unsigned coef_w,
                                              input int unsigned data_w,
                                              input int unsigned taps);
        return coef_w + data_w + $clog2(taps);
    endfunction

    function automatic int unsigned upd_shift(input int unsigned data_w,
                                              input int unsigned frac_w,
                                              input int unsigned mu_shift);
        return 2 * data_w - 2 - frac_w + mu_shift;
    endfunction

    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] x,
                                                        input int unsigned w);
        logic signed [63:0] maxv;
        logic signed [63:0] minv;
        maxv = (64'sd1 <<< (w - 1)) - 64'sd1;
        minv = -maxv - 64'sd1;
        if (x > maxv) return maxv;
        if (x < minv) return minv;
        return x;
    endfunction

    function automatic logic signed [63:0] round_shift(input logic signed [63:0] x,
                                                       input int unsigned s);
        if (s == 0) return x;
        return (x + (64'sd1 <<< (s - 1))) >>> s;
    endfunction

endpackage

// File: rtl/echo_sat_round.sv
// echo_sat_round: round-half-up arithmetic shift followed by saturation.
//   din  [IN_W]  - signed input word
//   dout [OUT_W] - sat_OUT_W(round(din >>> SHIFT))
module echo_sat_round
    import echo_pkg::*;
#(
    parameter int unsigned IN_W  = 46,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 22
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);

    always_comb begin
        dout = OUT_W'(sat_to_width(round_shift(64'($signed(din)), SHIFT), OUT_W));
    end

endmodule

// File: rtl/echo_canceller_lms.sv
// echo_canceller_lms: TAPS-long adaptive FIR echo canceller (LMS, mu=2^-MU_SHIFT).
// One shared multiplier, one tap per clock.
//   clk_operation       - clock, rising edge
//   rst                 - asynchronous active-low reset
//   enable              - one-cycle sample strobe
//   sig16b              - near-end sample (speech + echo)
//   sig16b_lag          - far-end reference sample
//   adapt_en            - allow the coefficient update pass (sampled in ERROR)
//   coef_clear          - zero all coefficients (deferred to IDLE entry if busy)
//   coef_rd_idx/data    - combinational coefficient readback
//   sig16b_without_echo - echo-free output e
//   out_valid           - one-cycle pulse when e updates
//   busy                - sample in progress
//   overrun             - sticky: enable seen while busy
module echo_canceller_lms
    import echo_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned TAPS     = 4,
    parameter int unsigned COEF_W   = 24,
    parameter int unsigned FRAC_W   = 22,
    parameter int unsigned MU_SHIFT = 8
) (
    input  logic                     clk_operation,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [DATA_W-1:0]        sig16b,
    input  logic [DATA_W-1:0]        sig16b_lag,
    input  logic                     adapt_en,
    input  logic                     coef_clear,
    input  logic [$clog2(TAPS)-1:0]  coef_rd_idx,
    output logic [COEF_W-1:0]        coef_rd_data,
    output logic [DATA_W-1:0]        sig16b_without_echo,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int unsigned KW    = $clog2(TAPS);
    localparam int unsigned AW    = acc_width(COEF_W, DATA_W, TAPS);
    localparam int unsigned MUL_W = COEF_W + DATA_W;
    localparam int unsigned PW    = 2 * DATA_W;
    localparam int unsigned SH    = upd_shift(DATA_W, FRAC_W, MU_SHIFT);

    state_t                    state;
    logic [KW-1:0]             k;
    logic signed [DATA_W-1:0]  x [TAPS];
    logic signed [COEF_W-1:0]  c [TAPS];
    logic signed [DATA_W-1:0]  d;
    logic signed [DATA_W-1:0]  e;
    logic signed [AW-1:0]      acc;
    logic                      pend_clr;

    logic signed [COEF_W-1:0]  mul_a;
    logic signed [MUL_W-1:0]   prod;
    logic signed [PW-1:0]      p;
    logic [DATA_W-1:0]         y_raw;
    logic [COEF_W-1:0]         delta_raw;
    logic signed [DATA_W-1:0]  e_next;
    logic signed [COEF_W-1:0]  c_next;
    logic                      last_tap;
    logic                      clr_now;

    // Shared multiplier: c[k]*x[k] while filtering, e*x[k] while updating.
    always_comb begin
        mul_a = (state == ST_UPDATE) ? COEF_W'(e) : c[k];
        prod  = MUL_W'(mul_a) * MUL_W'(x[k]);
    end

    // In UPDATE the product is e*x, which always fits in 2*DATA_W bits.
    assign p = PW'(prod);

    echo_sat_round #(.IN_W(AW), .OUT_W(DATA_W), .SHIFT(FRAC_W)) u_round_y (
        .din  (acc),
        .dout (y_raw)
    );

    echo_sat_round #(.IN_W(PW), .OUT_W(COEF_W), .SHIFT(SH)) u_round_delta (
        .din  (p),
        .dout (delta_raw)
    );

    always_comb begin
        e_next = DATA_W'(sat_to_width(64'(d) - 64'($signed(y_raw)), DATA_W));
        c_next = COEF_W'(sat_to_width(64'(c[k]) + 64'($signed(delta_raw)), COEF_W));
    end

    assign last_tap            = (k == KW'(TAPS - 1));
    assign clr_now             = pend_clr | coef_clear;
    assign busy                = (state != ST_IDLE);
    assign coef_rd_data        = c[coef_rd_idx];
    assign sig16b_without_echo = e;

    always_ff @(posedge clk_operation or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            k         <= '0;
            d         <= '0;
            e         <= '0;
            acc       <= '0;
            pend_clr  <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                x[i] <= '0;
                c[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (enable && state != ST_IDLE) overrun <= 1'b1;
            if (coef_clear && state != ST_IDLE) pend_clr <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (coef_clear) begin
                        for (int unsigned i = 0; i < TAPS; i++) c[i] <= '0;
                    end
                    if (enable) begin
                        for (int unsigned i = TAPS - 1; i > 0; i--) x[i] <= x[i-1];
                        x[0]  <= sig16b_lag;
                        d     <= sig16b;
                        acc   <= '0;
                        k     <= '0;
                        state <= ST_FILTER;
                    end
                end
                ST_FILTER: begin
                    acc <= acc + AW'(prod);
                    k   <= k + KW'(1);
                    if (last_tap) begin
                        k     <= '0;
                        state <= ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    e         <= e_next;
                    out_valid <= 1'b1;
                    k         <= '0;
                    if (adapt_en) begin
                        state <= ST_UPDATE;
                    end else begin
                        state <= ST_IDLE;
                        if (clr_now) begin
                            for (int unsigned i = 0; i < TAPS; i++) c[i] <= '0;
                            pend_clr <= 1'b0;
                        end
                    end
                end
                ST_UPDATE: begin
                    c[k] <= c_next;
                    k    <= k + KW'(1);
                    if (last_tap) begin
                        k     <= '0;
                        state <= ST_IDLE;
                        // A deferred clear overrides the final tap write.
                        if (clr_now) begin
                            for (int unsigned i = 0; i < TAPS; i++) c[i] <= '0;
                            pend_clr <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
